complex_fir_conv: RTL and testbench



---
 rtl/complex_fir_pkg.sv | 31 +++
 rtl/complex_fir_conv_mult.sv | 32 +++
 rtl/complex_fir_conv.sv | 96 +++++++++
 tb/tb_complex_fir_conv.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/complex_fir_pkg.sv
// Shared types and constants for the complex FIR convolver.
// Optional build macro: COMPLEX_FIR_COEF_LOAD_EN (adds a runtime coefficient
// write port to complex_fir_conv; this package is the same in both builds).
package complex_fir_pkg;

  localparam int TAPS   = 4;
  localparam int DATA_W = 16;
  localparam int COEF_W = 3;
  localparam int OUT_W  = 32;

  // One complex input sample; both halves are signed two's complement.
  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_sample_t;

  // One complex coefficient; each half covers -4..3.
  typedef struct packed {
    logic signed [COEF_W-1:0] re;
    logic signed [COEF_W-1:0] im;
  } cplx_coef_t;

  // Power-on / reset coefficient set, index 0 applies to the newest sample.
  localparam cplx_coef_t DEFAULT_COEFS [TAPS] = '{
    '{re:  3'sd1, im:  3'sd0},
    '{re:  3'sd2, im:  3'sd1},
    '{re: -3'sd1, im:  3'sd3},
    '{re:  3'sd0, im: -3'sd2}
  };

endpackage

// File: rtl/complex_fir_conv_mult.sv
// Combinational signed complex multiply: one sample times one coefficient.
// Both operands are widened to OUT_W first so the products and the later
// tap sum share one signed width and can never overflow.
module complex_mult
  import complex_fir_pkg::*;
(
  input  cplx_sample_t             sample,
  input  cplx_coef_t               coef,
  output logic signed [OUT_W-1:0]  prod_r,
  output logic signed [OUT_W-1:0]  prod_i
);

  logic signed [OUT_W-1:0] xr;
  logic signed [OUT_W-1:0] xi;
  logic signed [OUT_W-1:0] cr;
  logic signed [OUT_W-1:0] ci;

  // Sign-extend every operand half to the accumulation width.
  always_comb begin
    xr = OUT_W'($signed(sample.re));
    xi = OUT_W'($signed(sample.im));
    cr = OUT_W'($signed(coef.re));
    ci = OUT_W'($signed(coef.im));
  end

  // (xr + j xi)(cr + j ci) = (xr*cr - xi*ci) + j (xr*ci + xi*cr)
  always_comb begin
    prod_r = (xr * cr) - (xi * ci);
    prod_i = (xr * ci) + (xi * cr);
  end

endmodule

// File: rtl/complex_fir_conv.sv
// Streaming 4-tap complex FIR: y[n] = sum_k c[k] * x[n-k].
// One sample in and one registered result out every clock, no handshake.
// Latency: a sample captured at edge t first shows up (times c0) after t+1.
// Optional build macro: COMPLEX_FIR_COEF_LOAD_EN adds coef_we/coef_addr/
// coef_r_in/coef_i_in so the coefficients become writable registers that
// reset to the package defaults; without it the coefficients are constants.
module complex_fir_conv
  import complex_fir_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [DATA_W-1:0]  input_r,
  input  logic signed [DATA_W-1:0]  input_i,
`ifdef COMPLEX_FIR_COEF_LOAD_EN
  input  logic                      coef_we,
  input  logic [1:0]                coef_addr,
  input  logic signed [COEF_W-1:0]  coef_r_in,
  input  logic signed [COEF_W-1:0]  coef_i_in,
`endif
  output logic signed [OUT_W-1:0]   result_r,
  output logic signed [OUT_W-1:0]   result_i
);

  cplx_sample_t            x_line [TAPS];
  cplx_coef_t              coefs  [TAPS];
  logic signed [OUT_W-1:0] prod_r [TAPS];
  logic signed [OUT_W-1:0] prod_i [TAPS];
  logic signed [OUT_W-1:0] sum_r;
  logic signed [OUT_W-1:0] sum_i;

`ifdef COMPLEX_FIR_COEF_LOAD_EN
  // Writable coefficient bank; reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        coefs[k] <= DEFAULT_COEFS[k];
      end
    end else if (coef_we) begin
      coefs[coef_addr] <= '{re: coef_r_in, im: coef_i_in};
    end
  end
`else
  // Fixed coefficient bank taken straight from the package.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      coefs[k] = DEFAULT_COEFS[k];
    end
  end
`endif

  // Delay line: capture the new sample every cycle and age the older ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x_line[k] <= '0;
      end
    end else begin
      x_line[0] <= '{re: input_r, im: input_i};
      for (int k = 1; k < TAPS; k++) begin
        x_line[k] <= x_line[k-1];
      end
    end
  end

  // One complex multiplier per tap.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    complex_mult u_mult (
      .sample (x_line[k]),
      .coef   (coefs[k]),
      .prod_r (prod_r[k]),
      .prod_i (prod_i[k])
    );
  end

  // Add the tap products; the worst case is about 2^20, far inside OUT_W.
  always_comb begin
    sum_r = '0;
    sum_i = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_r = sum_r + prod_r[k];
      sum_i = sum_i + prod_i[k];
    end
  end

  // Output register samples the sum of the line as it stood before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_r <= '0;
      result_i <= '0;
    end else begin
      result_r <= sum_r;
      result_i <= sum_i;
    end
  end

endmodule

// File: tb/tb_complex_fir_conv.sv
// Self-checking bench for complex_fir_conv: a plain integer model of the
// filter equation checked every cycle, plus hand-computed directed checks.
// Build with COMPLEX_FIR_COEF_LOAD_EN defined to also exercise coefficient writes.
module tb_complex_fir_conv;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] input_r;
  logic signed [15:0] input_i;
  logic signed [31:0] result_r;
  logic signed [31:0] result_i;
`ifdef COMPLEX_FIR_COEF_LOAD_EN
  logic               coef_we;
  logic [1:0]         coef_addr;
  logic signed [2:0]  coef_r_in;
  logic signed [2:0]  coef_i_in;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: sample history (index 0 newest) and coefficient values.
  int hist_r [4];
  int hist_i [4];
  int mc_r   [4];
  int mc_i   [4];
  int exp_r  = 0;
  int exp_i  = 0;
  bit armed  = 0;
  int cycle  = 0;

  complex_fir_conv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .input_r   (input_r),
    .input_i   (input_i),
`ifdef COMPLEX_FIR_COEF_LOAD_EN
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_r_in (coef_r_in),
    .coef_i_in (coef_i_in),
`endif
    .result_r  (result_r),
    .result_i  (result_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: y = sum c[k]*x[n-k] over the history held before this edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        hist_r[k] = 0;
        hist_i[k] = 0;
      end
      mc_r  = '{1, 2, -1, 0};
      mc_i  = '{0, 1, 3, -2};
      exp_r = 0;
      exp_i = 0;
      armed = 1;
    end else begin
      exp_r = 0;
      exp_i = 0;
      for (int k = 0; k < 4; k++) begin
        exp_r += hist_r[k] * mc_r[k] - hist_i[k] * mc_i[k];
        exp_i += hist_r[k] * mc_i[k] + hist_i[k] * mc_r[k];
      end
      for (int k = 3; k > 0; k--) begin
        hist_r[k] = hist_r[k-1];
        hist_i[k] = hist_i[k-1];
      end
      hist_r[0] = int'(input_r);
      hist_i[0] = int'(input_i);
`ifdef COMPLEX_FIR_COEF_LOAD_EN
      if (coef_we) begin
        mc_r[coef_addr] = int'(coef_r_in);
        mc_i[coef_addr] = int'(coef_i_in);
      end
`endif
    end
  end

  // Every-cycle comparison of DUT against the model, away from the active edge.
  always @(negedge clk) begin
    cycle++;
    if (armed) begin
      checks++;
      if (result_r !== exp_r || result_i !== exp_i) begin
        errors++;
        $display("[TB] FAIL stream cycle %0d: got (%0d,%0d) expected (%0d,%0d)",
                 cycle, result_r, result_i, exp_r, exp_i);
      end
    end
  end

  // Drive one sample, then wait until the following falling edge.
  task automatic apply_stimulus(input int r, input int i);
    input_r = 16'(r);
    input_i = 16'(i);
    @(negedge clk);
  endtask

  // Compare the current outputs against a hand-computed literal.
  task automatic check_output(input string name, input int er, input int ei);
    checks++;
    if (result_r !== er || result_i !== ei) begin
      errors++;
      $display("[TB] FAIL %s: got (%0d,%0d) expected (%0d,%0d)",
               name, result_r, result_i, er, ei);
    end
  endtask

  // Single-sample impulse followed by zeros; check four taps then silence.
  task automatic impulse(input string name, input int r, input int i,
                         input int er [4], input int ei [4]);
    apply_stimulus(r, i);
    check_output({name, "_edge"}, 0, 0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, 0);
      check_output(name, er[k], ei[k]);
    end
    apply_stimulus(0, 0);
    check_output({name, "_tail"}, 0, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    input_r = '0;
    input_i = '0;
`ifdef COMPLEX_FIR_COEF_LOAD_EN
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_r_in = '0;
    coef_i_in = '0;
`endif

    // Reset held with a nonzero input must keep everything at zero.
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(500, 0);
      check_output("reset", 0, 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 0);
      check_output("post_reset_zero", 0, 0);
    end

    impulse("real_impulse", 1, 0, '{1, 2, -1, 0}, '{0, 1, 3, -2});
    impulse("imag_impulse", 0, 1, '{0, -1, -3, 2}, '{1, 2, -1, 0});

    // Constant inputs settle once four samples fill the line.
    for (int k = 0; k < 5; k++) apply_stimulus(100, 0);
    check_output("step_100", 200, 200);
    apply_stimulus(100, 0);
    check_output("step_100_hold", 200, 200);
    for (int k = 0; k < 5; k++) apply_stimulus(-32768, -32768);
    check_output("step_min", 0, -131072);
    apply_stimulus(-32768, -32768);
    check_output("step_min_hold", 0, -131072);

    // Ramp, then a one-cycle reset discards all history.
    for (int k = 0; k < 6; k++) apply_stimulus(k * 37 - 100, 50 - k * 11);
    rst_n = 1'b0;
    apply_stimulus(999, -999);
    check_output("mid_reset", 0, 0);
    rst_n = 1'b1;
    impulse("post_reset_impulse", 1, 0, '{1, 2, -1, 0}, '{0, 1, 3, -2});

`ifdef COMPLEX_FIR_COEF_LOAD_EN
    // Overwrite c0 only; the other taps keep their defaults.
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_r_in = 3'sd3;
    coef_i_in = -3'sd4;
    apply_stimulus(0, 0);
    coef_we = 1'b0;
    impulse("coef_load_impulse", 1, 0, '{3, 2, -1, 0}, '{-4, 1, 3, -2});
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
